// File: rtl/dtcm_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_arbiter_pkg
// Brief    : Shared types and constants for the DTCM core/DMA arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dtcm_arbiter_pkg;

    localparam int c_starve_max_def = 4;
    localparam int c_starve_cnt_wth = 4;

    typedef enum logic [0:0] {
        CORE_PRI  = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_t;

endpackage : dtcm_arbiter_pkg
`default_nettype wire

// File: rtl/dtcm_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_arb_starve_cnt
// Brief    : Saturating up-counter with synchronous clear (clear wins).
// Revision : 1.0 - initial release
// ============================================================================
module dtcm_arb_starve_cnt
    import dtcm_arbiter_pkg::*;
#(
    parameter int CNT_WTH = c_starve_cnt_wth,
    parameter int CNT_MAX = c_starve_max_def
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [CNT_WTH-1:0] o_cnt
);

    localparam logic [CNT_WTH-1:0] c_cnt_max = CNT_WTH'(CNT_MAX);
    localparam logic [CNT_WTH-1:0] c_cnt_one = CNT_WTH'(1);

    logic [CNT_WTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    assign o_cnt = r_cnt;

endmodule : dtcm_arb_starve_cnt
`default_nettype wire

// File: rtl/dtcm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dtcm_arbiter
// Brief    : Single-port DTCM arbiter, core priority with DMA anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module dtcm_arbiter
    import dtcm_arbiter_pkg::*;
#(
    parameter int WORD_WTH   = 32,
    parameter int ADDR_WTH   = 32,
    parameter int STARVE_MAX = c_starve_max_def
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [ADDR_WTH-1:0] core_addr_i,
    input  logic [WORD_WTH-1:0] core_wdata_i,
    output logic [WORD_WTH-1:0] core_rdata_o,
    output logic                core_stall_o,

    input  logic                dma_valid_i,
    output logic                dma_ready_o,
    input  logic                dma_we_i,
    input  logic [ADDR_WTH-1:0] dma_addr_i,
    input  logic [WORD_WTH-1:0] dma_wdata_i,
    output logic                dma_rvalid_o,
    output logic [WORD_WTH-1:0] dma_rdata_o,

    output logic [ADDR_WTH-1:0] dtcm_addr_o,
    output logic [WORD_WTH-1:0] dtcm_wdata_o,
    output logic                dtcm_we_o,
    input  logic [WORD_WTH-1:0] dtcm_rdata_i
);

    localparam logic [c_starve_cnt_wth-1:0] c_starve_hit =
        c_starve_cnt_wth'(STARVE_MAX - 1);

    arb_state_t                  r_state;
    logic                        r_dma_rvalid;
    logic [WORD_WTH-1:0]         r_dma_rdata;

    arb_state_t                  w_state_eff;
    logic                        w_core_gnt;
    logic                        w_dma_gnt;
    logic                        w_cnt_inc;
    logic                        w_cnt_clr;
    logic [c_starve_cnt_wth-1:0] w_starve_cnt;

    // Grants are decoded from the reset state while rst is high.
    assign w_state_eff = rst ? CORE_PRI : r_state;

    assign w_dma_gnt  = dma_valid_i && ((w_state_eff == DMA_FORCE) || !core_req_i);
    // An un-stalled core request must complete, including a withdrawn forced slot.
    assign w_core_gnt = core_req_i && !w_dma_gnt;

    assign dma_ready_o  = w_dma_gnt;
    assign core_stall_o = core_req_i && w_dma_gnt;
    assign core_rdata_o = dtcm_rdata_i;

    assign dtcm_addr_o  = w_dma_gnt ? dma_addr_i  : core_addr_i;
    assign dtcm_wdata_o = w_dma_gnt ? dma_wdata_i : core_wdata_i;
    assign dtcm_we_o    = w_dma_gnt ? dma_we_i    : (w_core_gnt && core_we_i);

    // A forced slot is single-shot, so leaving it always restarts the count.
    assign w_cnt_inc = dma_valid_i && !w_dma_gnt;
    assign w_cnt_clr = w_dma_gnt || (w_state_eff == DMA_FORCE);

    dtcm_arb_starve_cnt #(
        .CNT_WTH (c_starve_cnt_wth),
        .CNT_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_starve_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= CORE_PRI;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            case (r_state)
                CORE_PRI: begin
                    if (w_cnt_inc && (w_starve_cnt == c_starve_hit)) begin
                        r_state <= DMA_FORCE;
                    end
                end
                DMA_FORCE: r_state <= CORE_PRI;
                default:   r_state <= CORE_PRI;
            endcase

            r_dma_rvalid <= w_dma_gnt && !dma_we_i;
            if (w_dma_gnt && !dma_we_i) begin
                r_dma_rdata <= dtcm_rdata_i;
            end
        end
    end

    assign dma_rvalid_o = r_dma_rvalid;
    assign dma_rdata_o  = r_dma_rdata;

endmodule : dtcm_arbiter
`default_nettype wire

// File: doc/dtcm_arbiter.md
DTCM_ARBITER -- requirements
Module: dtcm_arbiter

Interface
REQ-001 Parameter WORD_WTH, default 32: data width.
REQ-002 Parameter ADDR_WTH, default 32: address width.
REQ-003 Parameter STARVE_MAX, default 4: consecutive denied DMA cycles before a forced DMA grant; legal range 1..15.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 core_req_i  input  1  MEM-stage access request; load or store.
REQ-007 core_we_i  input  1  MEM-stage store enable.
REQ-008 core_addr_i  input  ADDR_WTH  MEM-stage address (ALU result).
REQ-009 core_wdata_i  input  WORD_WTH  MEM-stage store data.
REQ-010 core_rdata_o  output  WORD_WTH  load data to MEM stage.
REQ-011 core_stall_o  output  1  to hazard unit: freeze MEM and earlier stages this cycle.
REQ-012 dma_valid_i  input  1  DMA/debug request valid.
REQ-013 dma_ready_o  output  1  DMA request accepted this cycle.
REQ-014 dma_we_i, dma_addr_i, dma_wdata_i  input  1/ADDR_WTH/WORD_WTH  DMA write enable, address and data.
REQ-015 dma_rvalid_o  output  1  DMA read data valid.
REQ-016 dma_rdata_o  output  WORD_WTH  DMA read data.
REQ-017 dtcm_addr_o, dtcm_wdata_o, dtcm_we_o  output  ADDR_WTH/WORD_WTH/1  single DTCM port.
REQ-018 dtcm_rdata_i  input  WORD_WTH  DTCM read data; combinational, same cycle as address.

Function
REQ-019 States: CORE_PRI and DMA_FORCE; plus a 4-bit starvation counter starve_cnt.
REQ-020 Grant rule:
- CORE_PRI: core is granted when core_req_i=1; otherwise DMA is granted when dma_valid_i=1.
- DMA_FORCE: DMA is granted when dma_valid_i=1.
REQ-021 dma_ready_o shall equal the DMA grant, combinationally, and shall never be 1 when dma_valid_i=0.
REQ-022 core_stall_o shall equal core_req_i AND DMA grant.
REQ-023 DTCM port signals shall be driven from the granted requester; dtcm_we_o shall be 0 when neither requester is granted.
REQ-024 core_rdata_o shall equal dtcm_rdata_i in every cycle.
REQ-025 On an accepted DMA read (dma_ready_o=1, dma_we_i=0), dma_rdata_o shall capture dtcm_rdata_i and dma_rvalid_o shall be 1 in the following cycle only (latency 1); DMA writes shall produce no rvalid.
REQ-026 dma_rdata_o shall hold its last value while dma_rvalid_o=0.
REQ-027 starve_cnt:
- increments (saturating at STARVE_MAX) each cycle with dma_valid_i=1 and DMA not granted;
- clears on any DMA grant;
- holds otherwise.
REQ-028 Transitions:
- CORE_PRI -> DMA_FORCE when starve_cnt reaches STARVE_MAX at the clock edge.
- DMA_FORCE -> CORE_PRI after one DMA grant.
- DMA_FORCE -> CORE_PRI, with starve_cnt cleared, if dma_valid_i drops before a grant.
REQ-029 Guarantee: at most one forced stall per STARVE_MAX+1 cycles; the core is never stalled for two consecutive cycles.
REQ-030 The core holds its request stable while stalled; the arbiter shall not latch core request fields.

Reset
REQ-031 On rst=1 at a clock edge: state=CORE_PRI, starve_cnt=0, dma_rvalid_o=0, dma_rdata_o=0.
REQ-032 A DMA read accepted in the cycle rst is asserted shall produce no dma_rvalid_o.
REQ-033 Combinational outputs shall follow REQ-020..024 during reset using the reset state.

Structure
REQ-034 The state encoding (CORE_PRI=1'b0, DMA_FORCE=1'b1) and the STARVE_MAX default shall live in the shared core package.
REQ-035 One sub-module is natural: dtcm_arb_starve_cnt, a saturating counter with clear; the rest is flat.

Verification
REQ-036 Core-only: core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF with no DMA -> dtcm_we_o=1, addr 0x10, core_stall_o=0.
REQ-037 DMA-only read: dma_valid=1, addr=0x20, DTCM returns 0x12345678 -> dma_ready_o=1 same cycle; dma_rvalid_o=1 with data 0x12345678 next cycle.
REQ-038 Starvation: core_req=1 and dma_valid=1 continuously, STARVE_MAX=4 -> DMA denied 4 cycles, granted on cycle 5 with core_stall_o=1, then the pattern repeats every 5 cycles.
REQ-039 Forced-grant withdrawal: state DMA_FORCE, dma_valid dropped -> no stall, return to CORE_PRI, starve_cnt=0.
REQ-040 Reset mid-read: DMA read accepted with rst=1 -> dma_rvalid_o stays 0; next cycle state=CORE_PRI.
REQ-041 Idle: no requests -> dtcm_we_o=0, dma_ready_o=0, core_stall_o=0.
